l1_l2_arbiter: RTL
==================

L1_L2_ARBITER -- requirements
Module: l1_l2_arbiter

Interface
REQ-001 SHALL have parameter ARB_MODE, default 1, meaning 0 = fixed priority (req0 wins) and 1 = round-robin.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles spent in WAIT before forced completion; legal range 1-255.
REQ-003 SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-004 Ports, in order:
  clk  in  1  system clock
  reset  in  1  synchronous active-high reset
  req0_valid  in  1  requester 0 (L1 instruction) transaction pending; held high until req0_done
  req0_addr  in  32  requester 0 byte address
  req0_we  in  1  requester 0 write (1) or read (0)
  req0_wdata  in  32  requester 0 write data
  req0_done  out  1  one-cycle completion pulse to requester 0
  req0_rdata  out  32  read data for requester 0; valid while req0_done=1
  req1_valid, req1_addr, req1_we, req1_wdata, req1_done, req1_rdata: as req0_*, for requester 1 (L1 data)
  l2_addrstb  out  1  one-cycle address strobe to L2
  l2_addr  out  32  address to L2
  l2_we  out  1  write enable to L2
  l2_wdata  out  32  write data to L2
  l2_rdata  in  32  read data from L2
  l2_stall  in  1  L2 busy; low means the current transaction is complete
  timeout_err  out  1  sticky flag, set on any WAIT timeout
  grant_cnt0  out  16  saturating count of grants to requester 0
  grant_cnt1  out  16  saturating count of grants to requester 1

Function
REQ-005 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-006 In IDLE, if any reqN_valid=1, SHALL latch the winner's addr, we and wdata, record it as the grant, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-007 Arbitration: with ARB_MODE=0, req0 SHALL win whenever both requesters are valid; with ARB_MODE=1, the requester not granted last SHALL win; a single valid requester SHALL always win.
REQ-008 ISSUE SHALL last exactly 1 cycle, with l2_addrstb=1 and l2_addr, l2_we and l2_wdata driven from the latched values; the next state SHALL be WAIT.
REQ-009 l2_addr, l2_we and l2_wdata SHALL hold the latched values from ISSUE through RESP inclusive and SHALL be 0 in IDLE.
REQ-010 In WAIT, if l2_stall=0, SHALL capture l2_rdata and go to RESP.
REQ-011 In WAIT, if l2_stall=1, SHALL increment the wait counter; when the counter reaches TIMEOUT, SHALL set timeout_err, capture rdata=32'h0 and go to RESP.
REQ-012 l2_stall SHALL be ignored outside WAIT.
REQ-013 RESP SHALL last exactly 1 cycle and assert reqN_done=1 only for the granted requester, with reqN_rdata equal to the captured data; the next state SHALL be IDLE.
REQ-014 For a write, rdata SHALL be the captured l2_rdata value, which requesters ignore.
REQ-015 reqN_rdata SHALL be 0 whenever reqN_done=0.
REQ-016 Minimum latency, with valid sampled in IDLE at edge 0: ISSUE in cycle 1, WAIT in cycle 2, done in cycle 3; each additional stall cycle SHALL add exactly 1 cycle.
REQ-017 If the granted requester drops valid before done, the transaction SHALL still complete and done SHALL still pulse.
REQ-018 A non-granted requester's valid SHALL remain pending, with no done pulse, until it is granted.
REQ-019 grant_cntN SHALL increment by 1 on each IDLE-to-ISSUE transition granting N, and SHALL saturate at 16'hFFFF without wrapping.
REQ-020 The round-robin last-grant register SHALL update only on a grant and SHALL be unaffected by ARB_MODE=0 operation.
REQ-021 Simultaneous completion and new requests: a request arriving during RESP SHALL be arbitrated in the following IDLE cycle, so transactions are spaced at least 4 cycles apart.
REQ-022 timeout_err SHALL be cleared only by reset.

Reset
REQ-023 Reset SHALL set the state to IDLE, all outputs to 0, the wait counter to 0, both grant counters to 0 and timeout_err to 0.
REQ-024 Reset SHALL set the last-grant register to requester 1, so req0 wins the first tie.
REQ-025 Reset asserted mid-transaction, in any state, SHALL abort it with no done pulse, and l2_addrstb=0 on the next cycle.

Verification
REQ-026 Single read: req0 read of addr 32'h0000_1000 with l2_stall low in WAIT and l2_rdata=32'hDEADBEEF -> l2_addrstb pulses in cycle 1, req0_done=1 with req0_rdata=32'hDEADBEEF in cycle 3, grant_cnt0=1.
REQ-027 Tie with round-robin: both requesters valid continuously after reset with ARB_MODE=1 -> grant order 0,1,0,1 and each transaction 4 cycles apart.
REQ-028 Fixed priority: both requesters valid with ARB_MODE=0 -> req0 is granted on every arbitration, req1 is never granted while req0 stays valid, and req1_done stays 0.
REQ-029 Stall and timeout: l2_stall held high for 10 cycles with TIMEOUT=255 -> done in cycle 13; l2_stall held high indefinitely with TIMEOUT=4 -> done with rdata=0 and timeout_err=1 until reset.
REQ-030 Reset in WAIT: a req1 write in flight when reset is pulsed -> no req1_done, all outputs 0, and the next req0/req1 tie grants req0.

Source files
------------

// File: rtl/l1_l2_arbiter.sv
// Two-requester (L1 I / L1 D) arbiter onto a single L2 port.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module l1_l2_arbiter #(
    parameter int ARB_MODE = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    input  logic        req0_we,
    input  logic [31:0] req0_wdata,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    input  logic        req1_we,
    input  logic [31:0] req1_wdata,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic        l2_addrstb,
    output logic [31:0] l2_addr,
    output logic        l2_we,
    output logic [31:0] l2_wdata,
    input  logic [31:0] l2_rdata,
    input  logic        l2_stall,
    output logic        timeout_err,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Last stall cycle allowed before the transaction is forced to complete.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        terr_q, terr_d;
    logic [15:0] gcnt0_q, gcnt0_d;
    logic [15:0] gcnt1_q, gcnt1_d;
    logic        win0;

    // req0 wins when alone, under fixed priority, or when req1 was granted last.
    assign win0 = req0_valid && (!req1_valid || (ARB_MODE == 0) || last_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wcnt_d  = wcnt_q;
        terr_d  = terr_q;
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d = ~win0;
                    addr_d  = win0 ? req0_addr  : req1_addr;
                    we_d    = win0 ? req0_we    : req1_we;
                    wdata_d = win0 ? req0_wdata : req1_wdata;
                    if (ARB_MODE != 0) last_d = ~win0;
                    if (win0 && gcnt0_q != 16'hFFFF) gcnt0_d = gcnt0_q + 16'd1;
                    if (!win0 && gcnt1_q != 16'hFFFF) gcnt1_d = gcnt1_q + 16'd1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wcnt_d  = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (!l2_stall) begin
                    rdata_d = l2_rdata;
                    state_d = RESP;
                end else if (wcnt_q == TO_LAST) begin
                    terr_d  = 1'b1;
                    rdata_d = 32'h0;
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            wcnt_q  <= '0;
            terr_q  <= 1'b0;
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wcnt_q  <= wcnt_d;
            terr_q  <= terr_d;
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    logic busy;
    assign busy        = (state_q != IDLE);
    assign l2_addrstb  = (state_q == ISSUE);
    assign l2_addr     = busy ? addr_q  : 32'h0;
    assign l2_we       = busy ? we_q    : 1'b0;
    assign l2_wdata    = busy ? wdata_q : 32'h0;
    assign req0_done   = (state_q == RESP) && !grant_q;
    assign req1_done   = (state_q == RESP) &&  grant_q;
    assign req0_rdata  = req0_done ? rdata_q : 32'h0;
    assign req1_rdata  = req1_done ? rdata_q : 32'h0;
    assign timeout_err = terr_q;
    assign grant_cnt0  = gcnt0_q;
    assign grant_cnt1  = gcnt1_q;

endmodule
